// File: rtl/joypad_scanner.sv
// ---------------------------------------------------------------------------
// joypad_scanner
//
// Periodically reads an NES-style serial controller and presents the eight
// button states as an active-high parallel word.
//
// A scan pulses joy_strobe for 2H cycles and waits H cycles of settle time.
// It then issues seven joy_clock high/low pairs of H cycles each (H =
// HALF_PERIOD) and sampling the synchronised data line at the end of the
// settle window and at the end of every low phase. The result is presented
// on cycle 17H of the scan together with a one-cycle buttons_valid pulse.
//
// Parameters
//   HALF_PERIOD    clock cycles per half bit-clock period (4..1023)
//   POLL_INTERVAL  clock cycles between automatic scan starts
//                  (>= 17*HALF_PERIOD + 2)
//
// Ports
//   clock          system clock, rising edge active
//   reset_n        asynchronous active-low reset
//   enable         permits new scans; a running scan always completes
//   poll_req       one-cycle request for an immediate scan (ignored if busy)
//   joy_data       serial data from the controller, active-low
//   joy_strobe     controller latch pulse
//   joy_clock      controller shift clock
//   buttons        {right,left,down,up,start,select,b,a}, active-high
//   buttons_valid  one-cycle pulse when buttons is written
//   busy           high while a scan is in progress
//
// Build option
//   JOYPAD_DEBOUNCE_EN  when defined, buttons is only written (and
//                       buttons_valid pulsed) when two consecutive scans
//                       return the same word.
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for poll expiry or poll_req while enabled
// LATCH  | joy_strobe high for 2H cycles
// SETTLE | H cycles after strobe; bit 0 sampled on the last cycle
// CLK_HI | joy_clock high for H cycles
// CLK_LO | joy_clock low for H cycles; next bit sampled on the last cycle
// DONE   | result presented, buttons_valid pulse, back to IDLE
//
module joypad_scanner #(
    parameter int HALF_PERIOD   = 64,
    parameter int POLL_INTERVAL = 357954
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       poll_req,
    input  logic       joy_data,
    output logic       joy_strobe,
    output logic       joy_clock,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic       busy
);

    localparam int              PW         = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [PW-1:0]   POLL_LOAD  = PW'(POLL_INTERVAL - 1);
    localparam logic [10:0]     HALF_LOAD  = 11'(HALF_PERIOD - 1);
    localparam logic [10:0]     LATCH_LOAD = 11'(2 * HALF_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETTLE,
        CLK_HI,
        CLK_LO,
        DONE
    } state_t;

    state_t          state;
    logic [10:0]     timer;
    logic [2:0]      bit_idx;
    logic [6:0]      shift_q;
    logic [PW-1:0]   poll_cnt;
    logic            sync_meta;
    logic            sync_data;
    logic            scan_start;
    logic            timer_done;
    logic [7:0]      scan_word;

`ifdef JOYPAD_DEBOUNCE_EN
    logic [7:0]      prev_word;
`endif

    assign timer_done = (timer == 11'd0);
    assign scan_start = (state == IDLE) && enable && ((poll_cnt == '0) || poll_req);

    // Bits 0..6 are already in shift_q; bit 7 is taken straight from the
    // synchroniser so the word is complete on the edge that enters DONE.
    assign scan_word  = {~sync_data, shift_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= 1'b0;
            sync_data <= 1'b0;
        end else begin
            sync_meta <= joy_data;
            sync_data <= sync_meta;
        end
    end

    // Poll timer: reloaded when a scan starts, saturates at zero so an
    // expired interval stays pending until enable allows the next scan.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt <= '0;
        end else if (scan_start) begin
            poll_cnt <= POLL_LOAD;
        end else if (poll_cnt != '0) begin
            poll_cnt <= poll_cnt - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            timer         <= 11'd0;
            bit_idx       <= 3'd0;
            shift_q       <= 7'd0;
            joy_strobe    <= 1'b0;
            joy_clock     <= 1'b0;
            buttons       <= 8'h00;
            buttons_valid <= 1'b0;
            busy          <= 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
            prev_word     <= 8'h00;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        state      <= LATCH;
                        timer      <= LATCH_LOAD;
                        joy_strobe <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                LATCH: begin
                    if (timer_done) begin
                        state      <= SETTLE;
                        timer      <= HALF_LOAD;
                        joy_strobe <= 1'b0;
                    end else begin
                        timer <= timer - 11'd1;
                    end
                end

                SETTLE: begin
                    if (timer_done) begin
                        shift_q   <= {~sync_data, shift_q[6:1]};
                        state     <= CLK_HI;
                        timer     <= HALF_LOAD;
                        joy_clock <= 1'b1;
                        bit_idx   <= 3'd1;
                    end else begin
                        timer <= timer - 11'd1;
                    end
                end

                CLK_HI: begin
                    if (timer_done) begin
                        state     <= CLK_LO;
                        timer     <= HALF_LOAD;
                        joy_clock <= 1'b0;
                    end else begin
                        timer <= timer - 11'd1;
                    end
                end

                CLK_LO: begin
                    if (timer_done) begin
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
`ifdef JOYPAD_DEBOUNCE_EN
                            prev_word <= scan_word;
                            if (scan_word == prev_word) begin
                                buttons       <= scan_word;
                                buttons_valid <= 1'b1;
                            end
`else
                            buttons       <= scan_word;
                            buttons_valid <= 1'b1;
`endif
                        end else begin
                            shift_q   <= {~sync_data, shift_q[6:1]};
                            state     <= CLK_HI;
                            timer     <= HALF_LOAD;
                            joy_clock <= 1'b1;
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        timer <= timer - 11'd1;
                    end
                end

                DONE: begin
                    buttons_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    joy_strobe <= 1'b0;
                    joy_clock  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joypad_scanner.sv
module tb_joypad_scanner;

    localparam int H = 4;
    localparam int P = 100;

`ifdef JOYPAD_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable  = 1'b0;
    logic       poll_req = 1'b0;
    logic       joy_data;
    logic       joy_strobe;
    logic       joy_clock;
    logic [7:0] buttons;
    logic       buttons_valid;
    logic       busy;

    logic [7:0] pattern = 8'hFF;
    int         idx = 0;

    int         err_cnt = 0;
    int         chk_cnt = 0;
    int         cyc = 0;
    int         hi_len = 0;
    int         pulses = 0;
    logic       strobe_d = 1'b0;
    logic       busy_d = 1'b0;

    joypad_scanner #(
        .HALF_PERIOD   (H),
        .POLL_INTERVAL (P)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .poll_req      (poll_req),
        .joy_data      (joy_data),
        .joy_strobe    (joy_strobe),
        .joy_clock     (joy_clock),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Controller model: strobe reloads the shift register (A first), every
    // rising joy_clock presents the next button. Output is active-low.
    always @(posedge joy_strobe or posedge joy_clock) begin
        if (joy_strobe)
            idx <= 0;
        else if (idx < 8)
            idx <= idx + 1;
    end
    assign joy_data = (idx < 8) ? ~pattern[idx[2:0]] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and run the continuous protocol checks.
    task automatic tick();
        @(negedge clock);
        cyc++;
        if (!reset_n) begin
            hi_len = 0;
        end else begin
            chk("strobe_clock_overlap", joy_strobe & joy_clock, 1'b0);
            if (joy_strobe && !strobe_d)
                pulses = 0;
            if (joy_clock) begin
                hi_len++;
            end else if (hi_len != 0) begin
                chk("clk_high_width", hi_len, H);
                pulses++;
                hi_len = 0;
            end
            if (busy_d && !busy)
                chk("clk_pulses_per_scan", pulses, 7);
        end
        strobe_d = joy_strobe;
        busy_d   = busy;
    endtask

    task automatic wait_start(input int max, output int n);
        n = 0;
        while (!joy_strobe && n < max) begin
            tick();
            n++;
        end
        chk("scan_start_timeout", joy_strobe, 1'b1);
    endtask

    // Called on the falling edge of scan cycle 0; walks through cycle 17H+1.
    task automatic scan_check(input string name, input logic [7:0] exp_btn,
                              input bit exp_valid, input int poll_at, input int drop_at);
        for (int c = 0; c <= 17*H+1; c++) begin
            if (c > 0) tick();
            poll_req = (c == poll_at);
            if (c == drop_at) enable = 1'b0;
            chk($sformatf("%s strobe c%0d", name, c), joy_strobe, (c < 2*H));
            chk($sformatf("%s jclk c%0d", name, c), joy_clock,
                (c >= 3*H) && (c < 17*H) && (((c - 3*H) / H) % 2 == 0));
            chk($sformatf("%s busy c%0d", name, c), busy, (c <= 17*H));
            chk($sformatf("%s valid c%0d", name, c), buttons_valid, exp_valid && (c == 17*H));
            if (c >= 17*H)
                chk($sformatf("%s buttons c%0d", name, c), buttons, exp_btn);
        end
        poll_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t_start;
        bit saw;

        reset_n = 1'b0;
        enable  = 1'b0;
        pattern = 8'hFF;
        repeat (3) tick();
        chk("reset_strobe", joy_strobe, 1'b0);
        chk("reset_jclk", joy_clock, 1'b0);
        chk("reset_buttons", buttons, 8'h00);
        chk("reset_valid", buttons_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);

        // first scan starts on the first edge with enable high
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_start(5, n);
        chk("first_start_latency", n, 1);
        t_start = cyc;
        scan_check("scan1", DEB ? 8'h00 : 8'hFF, !DEB, -1, -1);

        // poll_req during the scan must not start an extra scan
        wait_start(2*P, n);
        chk("poll_interval_1", cyc - t_start, P);
        t_start = cyc;
        scan_check("scan2", 8'hFF, 1'b1, 20, -1);

        pattern = 8'h09;
        wait_start(2*P, n);
        chk("poll_interval_2", cyc - t_start, P);
        t_start = cyc;
        scan_check("scan3", DEB ? 8'hFF : 8'h09, !DEB, -1, -1);

        // enable dropped mid-scan: scan completes, nothing follows
        wait_start(2*P, n);
        chk("poll_interval_3", cyc - t_start, P);
        scan_check("scan4", 8'h09, 1'b1, -1, 10);
        saw = 1'b0;
        repeat (2*P) begin
            tick();
            if (joy_strobe || busy) saw = 1'b1;
        end
        chk("no_scan_while_disabled", saw, 1'b0);
        chk("buttons_hold", buttons, 8'h09);

        // reset in the middle of a scan
        pattern = 8'h5A;
        enable  = 1'b1;
        wait_start(5, n);
        chk("restart_latency", n, 1);
        repeat (30) tick();
        chk("pre_reset_jclk", joy_clock, 1'b1);
        chk("pre_reset_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_strobe", joy_strobe, 1'b0);
        chk("async_reset_jclk", joy_clock, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_valid", buttons_valid, 1'b0);
        chk("async_reset_buttons", buttons, 8'h00);
        saw = 1'b0;
        repeat (3) begin
            tick();
            if (buttons_valid) saw = 1'b1;
        end
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (80) begin
            tick();
            if (buttons_valid || busy) saw = 1'b1;
        end
        chk("no_valid_after_abort", saw, 1'b0);
        chk("buttons_after_abort", buttons, 8'h00);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
